// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: ADC frequency-measurement sequencer (block-mean threshold, NPER-period timing, serial divide).
// Build option FREQ_HYST_EN: arm/fire around a saturated +/-HYST band about the mean instead of the bare mean.
module freq_meas_ctrl #(
  parameter int DATA_W     = 12,
  parameter int MEAN_LOG2  = 8,
  parameter int FREQ_CONST = 100000,
  parameter int NPER       = 1,
  parameter int TIMEOUT    = 65535,
  parameter int HYST       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] mean,
  output logic [31:0]       freq_out,
  output logic              freq_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int                   ACC_W     = DATA_W + MEAN_LOG2;
  localparam logic [31:0]          DIVIDEND  = 32'(FREQ_CONST * NPER);
  localparam logic [31:0]          TMO_LAST  = 32'(TIMEOUT - 1);
  localparam logic [3:0]           PER_LAST  = 4'(NPER - 1);
  localparam logic [MEAN_LOG2-1:0] MEAN_LAST = '1;
`ifdef FREQ_HYST_EN
  localparam logic [DATA_W-1:0]    BAND      = DATA_W'(HYST);
`else
  // Zero band: both thresholds collapse onto the mean itself.
  localparam logic [DATA_W-1:0]    BAND      = DATA_W'(0 * HYST);
`endif

  typedef enum logic [2:0] {IDLE, MEAN, SYNC, COUNT, DIV, DONE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_accNext;
  logic [MEAN_LOG2-1:0]  r_meanCnt;
  logic [DATA_W-1:0]     r_mean;
  logic                  r_armed;
  logic [31:0]           r_toCnt;
  logic [31:0]           r_sampCnt;
  logic [3:0]            r_perCnt;
  logic [31:0]           r_divisor;
  logic [31:0]           r_rem;
  logic [31:0]           r_quo;
  logic [4:0]            r_bitCnt;
  logic                  r_isTimeout;
  logic [31:0]           r_freqOut;
  logic                  r_freqValid;
  logic                  r_timeout;
  logic [DATA_W-1:0]     w_lowTh;
  logic [DATA_W-1:0]     w_highTh;
  logic [DATA_W:0]       w_highSum;
  logic                  w_below;
  logic                  w_above;
  logic                  w_fire;
  logic                  w_meanLast;
  logic                  w_toHit;
  logic                  w_lastPeriod;
  logic [32:0]           w_remShift;
  logic [31:0]           w_remSub;
  logic                  w_qBit;

  assign w_lowTh   = (r_mean >= BAND) ? (r_mean - BAND) : '0;
  assign w_highSum = {1'b0, r_mean} + {1'b0, BAND};
  assign w_highTh  = w_highSum[DATA_W] ? '1 : w_highSum[DATA_W-1:0];

  assign w_below      = (data < w_lowTh);
  assign w_above      = (data > w_highTh);
  assign w_fire       = sample_valid && r_armed && w_above;
  assign w_meanLast   = (r_meanCnt == MEAN_LAST);
  assign w_toHit      = sample_valid && (r_toCnt == TMO_LAST);
  assign w_lastPeriod = (r_perCnt == PER_LAST);
  assign w_accNext    = r_acc + ACC_W'(data);

  // One restoring-division step: the remainder never exceeds the divisor, so 32 bits hold it after subtracting.
  assign w_remShift = {r_rem, r_quo[31]};
  assign w_remSub   = w_remShift[31:0] - r_divisor;
  assign w_qBit     = (w_remShift >= {1'b0, r_divisor});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (run) w_nextState = MEAN;
      MEAN:    if (!run) w_nextState = IDLE;
               else if (sample_valid && w_meanLast) w_nextState = SYNC;
      SYNC:    if (!run) w_nextState = IDLE;
               else if (w_toHit) w_nextState = DONE;
               else if (w_fire) w_nextState = COUNT;
      COUNT:   if (!run) w_nextState = IDLE;
               else if (w_toHit) w_nextState = DONE;
               else if (w_fire && w_lastPeriod) w_nextState = DIV;
      DIV:     if (!run) w_nextState = IDLE;
               else if (r_bitCnt == 5'd31) w_nextState = DONE;
      DONE:    w_nextState = run ? MEAN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: every update is gated by run so an abort leaves the published results untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_meanCnt   <= '0;
      r_mean      <= '0;
      r_armed     <= 1'b0;
      r_toCnt     <= '0;
      r_sampCnt   <= '0;
      r_perCnt    <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_bitCnt    <= '0;
      r_isTimeout <= 1'b0;
      r_freqOut   <= '0;
      r_freqValid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_freqValid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc     <= '0;
          r_meanCnt <= '0;
        end
        MEAN: if (run && sample_valid) begin
          r_acc     <= w_accNext;
          r_meanCnt <= r_meanCnt + MEAN_LOG2'(1);
          if (w_meanLast) begin
            r_mean  <= w_accNext[MEAN_LOG2 +: DATA_W];
            r_armed <= 1'b0;
            r_toCnt <= '0;
          end
        end
        SYNC, COUNT: if (run && sample_valid) begin
          r_toCnt <= r_toCnt + 32'd1;
          if (w_below)     r_armed <= 1'b1;
          else if (w_fire) r_armed <= 1'b0;
          if (r_state == SYNC) begin
            if (w_fire) begin
              r_perCnt  <= '0;
              r_sampCnt <= '0;
            end
          end else begin
            r_sampCnt <= r_sampCnt + 32'd1;
            if (w_fire) begin
              r_perCnt <= r_perCnt + 4'd1;
              if (w_lastPeriod) begin
                r_divisor   <= r_sampCnt + 32'd1;
                r_rem       <= '0;
                r_quo       <= DIVIDEND;
                r_bitCnt    <= '0;
                r_isTimeout <= 1'b0;
              end
            end
          end
          if (w_toHit) r_isTimeout <= 1'b1;
        end
        DIV: if (run) begin
          r_rem    <= w_qBit ? w_remSub : w_remShift[31:0];
          r_quo    <= {r_quo[30:0], w_qBit};
          r_bitCnt <= r_bitCnt + 5'd1;
        end
        DONE: begin
          r_freqValid <= 1'b1;
          r_freqOut   <= r_isTimeout ? 32'd0 : r_quo;
          r_timeout   <= r_isTimeout;
          r_acc       <= '0;
          r_meanCnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mean       = r_mean;
  assign freq_out   = r_freqOut;
  assign freq_valid = r_freqValid;
  assign timeout    = r_timeout;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: directed bench for freq_meas_ctrl; one NPER=1 and one NPER=4 instance share the sample stream.
// Expectations follow the FREQ_HYST_EN build option where the noise pattern is concerned.
module tb_freq_meas_ctrl;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run1;
  logic        run4;
  logic        sampleValid;
  logic [11:0] data;
  logic [11:0] mean1, mean4;
  logic [31:0] freq1, freq4;
  logic        fv1, fv4, tmo1, tmo4, busy1, busy4;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          sampCyc [0:1999];
  logic [11:0] meanTrace [0:1999];
  int          fvCnt1, fvCyc1, fvCnt4, fvCyc4;
  logic [31:0] fvFreq1, fvFreq4;
  logic        fvTmo1, fvTmo4;
  logic        busyAfterDrop;
  logic [31:0] expFreq;
  logic        expTmo;

  always #5 clk = ~clk;

  freq_meas_ctrl #(.NPER(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .run(run1), .sample_valid(sampleValid), .data(data),
    .mean(mean1), .freq_out(freq1), .freq_valid(fv1), .timeout(tmo1), .busy(busy1)
  );

  freq_meas_ctrl #(.NPER(4), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst(rst), .run(run4), .sample_valid(sampleValid), .data(data),
    .mean(mean4), .freq_out(freq4), .freq_valid(fv4), .timeout(tmo4), .busy(busy4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, pass the edge, then log any result pulse from either instance.
  task automatic applyStimulus(input logic valid, input logic [11:0] value);
    sampleValid = valid;
    data        = value;
    @(posedge clk);
    #1;
    cyc++;
    if (fv1) begin
      fvCnt1++;
      if (fvCnt1 == 1) begin
        fvCyc1 = cyc; fvFreq1 = freq1; fvTmo1 = tmo1;
      end
    end
    if (fv4) begin
      fvCnt4++;
      if (fvCnt4 == 1) begin
        fvCyc4 = cyc; fvFreq4 = freq4; fvTmo4 = tmo4;
      end
    end
  endtask

  task automatic clearMonitor();
    fvCnt1 = 0; fvCyc1 = 0; fvFreq1 = 'x; fvTmo1 = 1'bx;
    fvCnt4 = 0; fvCyc4 = 0; fvFreq4 = 'x; fvTmo4 = 1'bx;
    busyAfterDrop = 1'bx;
  endtask

  function automatic logic [11:0] genSample(input int pattern, input int idx);
    case (pattern)
      0:       genSample = ((idx % 100) < 50) ? 12'd4000 : 12'd0;
      1:       genSample = 12'd2000;
      default: genSample = ((idx % 2) == 0) ? 12'd2008 : 12'd1992;
    endcase
  endfunction

  // Return both instances to IDLE, then start them so the next valid sample is the first one in MEAN.
  task automatic beginMeasurement(input logic r1, input logic r4);
    run1 = 1'b0; run4 = 1'b0;
    applyStimulus(1'b0, 12'd0);
    run1 = r1; run4 = r4;
    applyStimulus(1'b0, 12'd0);
    clearMonitor();
  endtask

  task automatic driveSamples(input int pattern, input int nSamples, input int validEvery, input int dropAt);
    for (int i = 0; i < nSamples; i++) begin
      if (i == dropAt) begin
        run1 = 1'b0; run4 = 1'b0;
        applyStimulus(1'b0, 12'd0);
        busyAfterDrop = busy1;
      end
      for (int g = 1; g < validEvery; g++) applyStimulus(1'b0, 12'd0);
      applyStimulus(1'b1, genSample(pattern, i));
      sampCyc[i]   = cyc;
      meanTrace[i] = mean1;
    end
  endtask

  initial begin
    rst = 1'b1; run1 = 1'b0; run4 = 1'b0; sampleValid = 1'b0; data = '0;
    clearMonitor();
    #2;
    checkOutput("rst_mean", 32'(mean1), 32'd0);
    checkOutput("rst_freq", freq1, 32'd0);
    checkOutput("rst_valid", 32'(fv1), 32'd0);
    checkOutput("rst_timeout", 32'(tmo1), 32'd0);
    checkOutput("rst_busy", 32'(busy1), 32'd0);
    #10 rst = 1'b0;

    // Square wave, valid every clock, NPER=1.
    beginMeasurement(1'b1, 1'b0);
    checkOutput("sq_busy", 32'(busy1), 32'd1);
    driveSamples(0, 450, 1, -1);
    checkOutput("sq_mean_before", 32'(meanTrace[254]), 32'd0);
    checkOutput("sq_mean", 32'(meanTrace[255]), 32'd2343);
    checkOutput("sq_pulses", 32'(fvCnt1), 32'd1);
    checkOutput("sq_latency", 32'(fvCyc1 - sampCyc[400]), 32'd33);
    checkOutput("sq_freq", fvFreq1, 32'd1000);
    checkOutput("sq_timeout", 32'(fvTmo1), 32'd0);

    // Same wave, valid 1 clock in 3, both NPER=1 and NPER=4.
    beginMeasurement(1'b1, 1'b1);
    driveSamples(0, 760, 3, -1);
    checkOutput("sparse_mean", 32'(meanTrace[255]), 32'd2343);
    checkOutput("sparse_pulses", 32'(fvCnt1), 32'd1);
    checkOutput("sparse_latency", 32'(fvCyc1 - sampCyc[400]), 32'd33);
    checkOutput("sparse_freq", fvFreq1, 32'd1000);
    checkOutput("n4_mean", 32'(mean4), 32'd2343);
    checkOutput("n4_pulses", 32'(fvCnt4), 32'd1);
    checkOutput("n4_latency", 32'(fvCyc4 - sampCyc[700]), 32'd33);
    checkOutput("n4_freq", fvFreq4, 32'd1000);

    // Constant input never crosses: timeout after TMO valid samples in SYNC.
    beginMeasurement(1'b1, 1'b0);
    driveSamples(1, 1300, 1, -1);
    checkOutput("const_mean", 32'(meanTrace[255]), 32'd2000);
    checkOutput("const_pulses", 32'(fvCnt1), 32'd1);
    checkOutput("const_latency", 32'(fvCyc1 - sampCyc[1255]), 32'd1);
    checkOutput("const_freq", fvFreq1, 32'd0);
    checkOutput("const_timeout", 32'(fvTmo1), 32'd1);
    checkOutput("const_rearm_busy", 32'(busy1), 32'd1);

    // +/-8 LSB alternating noise around 2000.
    beginMeasurement(1'b1, 1'b0);
`ifdef FREQ_HYST_EN
    driveSamples(2, 1300, 1, -1);
    checkOutput("noise_latency", 32'(fvCyc1 - sampCyc[1255]), 32'd1);
    expFreq = 32'd0; expTmo = 1'b1;
`else
    driveSamples(2, 300, 1, -1);
    checkOutput("noise_latency", 32'(fvCyc1 - sampCyc[260]), 32'd33);
    expFreq = 32'd50000; expTmo = 1'b0;
`endif
    checkOutput("noise_mean", 32'(meanTrace[255]), 32'd2000);
    checkOutput("noise_pulses", 32'(fvCnt1), 32'd1);
    checkOutput("noise_freq", fvFreq1, expFreq);
    checkOutput("noise_timeout", 32'(fvTmo1), 32'(expTmo));

    // run dropped mid-COUNT (COUNT spans samples 301..400).
    beginMeasurement(1'b1, 1'b0);
    driveSamples(0, 380, 1, 350);
    checkOutput("dropcnt_busy", 32'(busyAfterDrop), 32'd0);
    checkOutput("dropcnt_pulses", 32'(fvCnt1), 32'd0);
    checkOutput("dropcnt_freq", freq1, expFreq);
    checkOutput("dropcnt_timeout", 32'(tmo1), 32'(expTmo));
    checkOutput("dropcnt_mean", 32'(mean1), 32'd2343);

    // run dropped mid-DIV (divide starts after sample 400).
    beginMeasurement(1'b1, 1'b0);
    driveSamples(0, 450, 1, 410);
    checkOutput("dropdiv_busy", 32'(busyAfterDrop), 32'd0);
    checkOutput("dropdiv_pulses", 32'(fvCnt1), 32'd0);
    checkOutput("dropdiv_freq", freq1, expFreq);
    checkOutput("dropdiv_timeout", 32'(tmo1), 32'(expTmo));
    checkOutput("dropdiv_mean", 32'(mean1), 32'd2343);

    // Asynchronous reset between edges mid-DIV, then a fresh measurement with run held high.
    beginMeasurement(1'b1, 1'b0);
    driveSamples(0, 406, 1, -1);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_mean", 32'(mean1), 32'd0);
    checkOutput("arst_freq", freq1, 32'd0);
    checkOutput("arst_valid", 32'(fv1), 32'd0);
    checkOutput("arst_timeout", 32'(tmo1), 32'd0);
    checkOutput("arst_busy", 32'(busy1), 32'd0);
    #2 rst = 1'b0;
    applyStimulus(1'b0, 12'd0);
    clearMonitor();
    driveSamples(0, 450, 1, -1);
    checkOutput("arst_new_mean", 32'(meanTrace[255]), 32'd2343);
    checkOutput("arst_new_pulses", 32'(fvCnt1), 32'd1);
    checkOutput("arst_new_freq", fvFreq1, 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Sequencing controller for the ADC frequency-measurement path. It gates incoming ADC samples and acquires a block mean as the crossing threshold. It then times NPER signal periods in sample counts and divides the scaled sample rate by that count with a multi-cycle divider. Sits between the ADC sample stream and the VGA display logic, presenting one `freq_out` value per measurement with a valid strobe.

## Interface
- `DATA_W`, 12, ADC sample width
- `MEAN_LOG2`, 8, log2 of samples averaged per mean acquisition
- `FREQ_CONST`, 100000, sample rate in Hz (numerator constant)
- `NPER`, 1, rising crossings (periods) counted per measurement, 1..15
- `TIMEOUT`, 65535, max samples in SYNC+COUNT before abort
- `HYST`, 16, hysteresis half-band in LSBs (used only with `FREQ_HYST_EN`)

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous reset, active-high
- `run`  in  1  level; high = measure continuously
- `sample_valid`  in  1  `data` qualifier, one sample per high cycle
- `data`  in  DATA_W  ADC sample, unsigned
- `mean`  out  DATA_W  last acquired block mean
- `freq_out`  out  32  last frequency result, Hz
- `freq_valid`  out  1  one-cycle pulse: new `freq_out`/`timeout`
- `timeout`  out  1  last result was a timeout
- `busy`  out  1  state != IDLE

## Operation
- Reset values:
  - `mean`=0, `freq_out`=0, `freq_valid`=0, `timeout`=0, `busy`=0.
  - State IDLE; all counters and the accumulator cleared.
- States:
  - IDLE: leave to MEAN when `run`=1.
  - MEAN: accumulate 2^MEAN_LOG2 valid samples in a DATA_W+MEAN_LOG2 accumulator. Then `mean` <= sum >> MEAN_LOG2 (truncate). Go to SYNC.
  - SYNC: wait for the first rising crossing. Go to COUNT; `per_cnt`=0, `samp_cnt`=0.
  - COUNT: `samp_cnt`+1 per valid sample, including the crossing sample. On each rising crossing `per_cnt`+1. When `per_cnt` reaches NPER, go to DIV.
  - DIV: restoring divide of FREQ_CONST*NPER (32-bit) by `samp_cnt` (zero-extended to 32). One quotient bit per clock, 32 clocks, unsigned; the quotient is truncated.
  - DONE: `freq_out` <= quotient, `timeout`<=0, `freq_valid`=1 for this cycle. Go to MEAN if `run`, else IDLE.
- Rising crossing: the detector is armed by a valid sample below the low threshold. It fires on the next valid sample above the high threshold, then disarms. The arm state is cleared on entry to SYNC.
- Timeout: a single counter of valid samples spans SYNC+COUNT. When it reaches TIMEOUT, `freq_out`<=0, `timeout`<=1, `freq_valid` pulses, go to MEAN (or IDLE if `!run`).
- `run` low in MEAN/SYNC/COUNT/DIV aborts to IDLE on the next clock. There is no `freq_valid`, and `mean`/`freq_out`/`timeout` hold their previous values.
- Samples with `sample_valid`=0 are ignored in every state.
- `samp_cnt` is at least 2 on entry to DIV, so no divide-by-zero path exists.

## Timing
- `freq_valid` asserts exactly 33 clocks after the clock that registers the final crossing sample: 32 DIV clocks plus 1 DONE clock.
- The timeout `freq_valid` asserts 1 clock after the TIMEOUT-th valid sample is registered.
- `mean` updates 1 clock after the 2^MEAN_LOG2-th valid sample in MEAN.
- `rst` takes effect immediately, with no clock required, including mid-DIV. The first clock edge after `rst` deasserts starts from IDLE.
- No back-pressure: the consumer must capture on `freq_valid`.

## Configuration
- `FREQ_HYST_EN` defined:
  - low threshold = `mean`−HYST, high threshold = `mean`+HYST, both saturated to 0 and 2^DATA_W−1.
- `FREQ_HYST_EN` undefined:
  - low threshold = high threshold = `mean`; arm on `data`<`mean`, fire on `data`>`mean`.
  - HYST is unused.

## Test plan
- Square wave, 50 samples 4000 then 50 samples 0, `sample_valid` every clock, NPER=1 -> `mean`=2343 and `freq_out`=1000, with `freq_valid` 33 clocks after the second rising edge.
- Same wave with `sample_valid` high 1 clock in 3 -> identical `mean`/`freq_out`=1000. NPER=4 -> still 1000, measured over 400 samples.
- Constant `data`=2000 -> `freq_valid` with `freq_out`=0, `timeout`=1 after TIMEOUT valid samples in SYNC; then re-enters MEAN.
- ±8 LSB alternating noise around 2000 -> with `FREQ_HYST_EN` and HYST=16: timeout, `freq_out`=0. Without it: crossings every 2 samples, `freq_out`=50000.
- `run` dropped mid-COUNT, and separately mid-DIV -> `busy`=0 next clock, no `freq_valid`, `freq_out`/`mean` unchanged.
- `rst` pulsed asynchronously (between clock edges) mid-DIV -> all outputs zero immediately; with `run`=1 after release, a full new measurement gives `freq_out`=1000.
